// File: rtl/spart_core.sv
// spart_core: register-mapped serial port with a programmable baud generator,
// a single-byte transmit buffer feeding a serializer, and a 16x oversampling
// receiver with a single-byte receive buffer.
//
// Ports:
//   clk      system clock, all state on the rising edge
//   rst      synchronous active-high reset
//   iocs     chip select, one bus access per edge while high
//   iorw     1 = read (core drives databus), 0 = write
//   ioaddr   00 TX/RX buffer, 01 status, 10 divisor low, 11 divisor high
//   databus  bidirectional 8-bit data bus
//   rda      receive data available
//   tbr      transmit buffer ready (empty)
//   txd      serial transmit line, idle high
//   rxd      serial receive line, asynchronous to clk
module spart_core #(
  parameter logic [15:0] DIV_RESET   = 16'h0516,
  parameter int          SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic                   bus_wr;
  logic                   bus_rd;
  logic [7:0]             rd_data;
  logic [15:0]            divisor;
  logic [15:0]            baud_cnt;
  logic                   tick;
  logic [SYNC_STAGES-1:0] rx_sync;
  logic                   rx_s;

  tx_state_t  tx_state;
  logic [7:0] tx_buf;
  logic [7:0] tx_shift;
  logic [3:0] tx_tick_cnt;
  logic [2:0] tx_bit_cnt;
  logic       tx_armed;

  rx_state_t  rx_state;
  logic [7:0] rx_buf;
  logic [7:0] rx_shift;
  logic [3:0] rx_tick_cnt;
  logic [2:0] rx_bit_cnt;
  logic       ferr;

  assign bus_wr = iocs & ~iorw;
  assign bus_rd = iocs & iorw;
  assign tick   = (baud_cnt == 16'd0);
  assign rx_s   = rx_sync[SYNC_STAGES-1];

  always_comb begin
    rd_data = rx_buf;
    if (ioaddr[0])
      rd_data = {5'b0, ferr, tbr, rda};
  end

  // The divisor registers are write-only, so only addresses 00/01 drive the bus.
  assign databus = (iocs && iorw && !ioaddr[1]) ? rd_data : 8'bz;

  // Writing the high byte reloads the counter so a new rate starts immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      divisor  <= DIV_RESET;
      baud_cnt <= DIV_RESET;
    end else begin
      if (bus_wr && ioaddr == 2'b10)
        divisor[7:0] <= databus;
      if (bus_wr && ioaddr == 2'b11) begin
        divisor[15:8] <= databus;
        baud_cnt      <= {databus, divisor[7:0]};
      end else if (tick) begin
        baud_cnt <= divisor;
      end else begin
        baud_cnt <= baud_cnt - 16'd1;
      end
    end
  end

  // rxd is asynchronous; resetting the chain to 1 avoids a false start bit.
  always_ff @(posedge clk) begin
    if (rst)
      rx_sync <= '1;
    else
      rx_sync <= (rx_sync << 1) | SYNC_STAGES'(rxd);
  end

  // Transmitter. tx_armed marks that the start bit has begun on a tick edge,
  // so every bit lasts exactly 16 ticks. A buffered byte at the end of STOP
  // goes straight into the next start bit for back-to-back frames. tbr is
  // cleared only when empty and set only when full, so the two never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state    <= TX_IDLE;
      txd         <= 1'b1;
      tbr         <= 1'b1;
      tx_buf      <= 8'h00;
      tx_shift    <= 8'h00;
      tx_tick_cnt <= 4'd0;
      tx_bit_cnt  <= 3'd0;
      tx_armed    <= 1'b0;
    end else begin
      if (bus_wr && ioaddr == 2'b00 && tbr) begin
        tx_buf <= databus;
        tbr    <= 1'b0;
      end
      case (tx_state)
        TX_IDLE: begin
          txd <= 1'b1;
          if (!tbr) begin
            tx_shift    <= tx_buf;
            tbr         <= 1'b1;
            tx_armed    <= 1'b0;
            tx_tick_cnt <= 4'd0;
            tx_state    <= TX_START;
          end
        end
        TX_START: begin
          if (tick) begin
            if (!tx_armed) begin
              tx_armed    <= 1'b1;
              txd         <= 1'b0;
              tx_tick_cnt <= 4'd0;
            end else if (tx_tick_cnt == 4'd15) begin
              txd         <= tx_shift[0];
              tx_shift    <= {1'b0, tx_shift[7:1]};
              tx_bit_cnt  <= 3'd0;
              tx_tick_cnt <= 4'd0;
              tx_state    <= TX_DATA;
            end else begin
              tx_tick_cnt <= tx_tick_cnt + 4'd1;
            end
          end
        end
        TX_DATA: begin
          if (tick) begin
            if (tx_tick_cnt == 4'd15) begin
              tx_tick_cnt <= 4'd0;
              if (tx_bit_cnt == 3'd7) begin
                txd      <= 1'b1;
                tx_state <= TX_STOP;
              end else begin
                txd        <= tx_shift[0];
                tx_shift   <= {1'b0, tx_shift[7:1]};
                tx_bit_cnt <= tx_bit_cnt + 3'd1;
              end
            end else begin
              tx_tick_cnt <= tx_tick_cnt + 4'd1;
            end
          end
        end
        TX_STOP: begin
          if (tick) begin
            if (tx_tick_cnt == 4'd15) begin
              tx_tick_cnt <= 4'd0;
              if (!tbr) begin
                tx_shift <= tx_buf;
                tbr      <= 1'b1;
                txd      <= 1'b0;
                tx_armed <= 1'b1;
                tx_state <= TX_START;
              end else begin
                tx_state <= TX_IDLE;
              end
            end else begin
              tx_tick_cnt <= tx_tick_cnt + 4'd1;
            end
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // Receiver. The start bit is rechecked 8 ticks after the falling edge, and
  // later bits are sampled 16 ticks apart. Bus clears of rda/ferr come before
  // the frame logic so that a completing frame wins on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state    <= RX_IDLE;
      rx_buf      <= 8'h00;
      rx_shift    <= 8'h00;
      rx_tick_cnt <= 4'd0;
      rx_bit_cnt  <= 3'd0;
      rda         <= 1'b0;
      ferr        <= 1'b0;
    end else begin
      if (bus_rd && ioaddr == 2'b00)
        rda <= 1'b0;
      if (bus_rd && ioaddr == 2'b01)
        ferr <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (tick && !rx_s) begin
            rx_tick_cnt <= 4'd0;
            rx_state    <= RX_START;
          end
        end
        RX_START: begin
          if (tick) begin
            if (rx_tick_cnt == 4'd7) begin
              rx_tick_cnt <= 4'd0;
              rx_bit_cnt  <= 3'd0;
              rx_state    <= rx_s ? RX_IDLE : RX_DATA;
            end else begin
              rx_tick_cnt <= rx_tick_cnt + 4'd1;
            end
          end
        end
        RX_DATA: begin
          if (tick) begin
            if (rx_tick_cnt == 4'd15) begin
              rx_tick_cnt <= 4'd0;
              rx_shift    <= {rx_s, rx_shift[7:1]};
              rx_bit_cnt  <= rx_bit_cnt + 3'd1;
              if (rx_bit_cnt == 3'd7)
                rx_state <= RX_STOP;
            end else begin
              rx_tick_cnt <= rx_tick_cnt + 4'd1;
            end
          end
        end
        RX_STOP: begin
          if (tick) begin
            if (rx_tick_cnt == 4'd15) begin
              rx_tick_cnt <= 4'd0;
              rx_state    <= RX_IDLE;
              if (rx_s) begin
                rx_buf <= rx_shift;
                rda    <= 1'b1;
              end else begin
                ferr <= 1'b1;
              end
            end else begin
              rx_tick_cnt <= rx_tick_cnt + 4'd1;
            end
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spart_core.sv
// tb_spart_core: randomized self-checking bench for spart_core. A txd monitor
// decodes frames from the expected bit period, and receive frames are
// bit-banged onto rxd (or looped back from txd) with known contents.
module tb_spart_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  wire  [7:0] databus;
  logic [7:0] tb_data;
  logic       tb_drive;
  logic       rda;
  logic       tbr;
  logic       txd;
  logic       tb_rxd;
  logic       loopback;
  logic       rxd;
  logic       mon_en;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int bit_cycles = 64;

  logic [7:0] tx_data_q[$];
  int         tx_start_q[$];
  logic       tx_stop_q[$];

  assign databus = tb_drive ? tb_data : 8'bz;
  assign rxd     = loopback ? txd : tb_rxd;

  spart_core #(.DIV_RESET(16'h0516), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
    .databus(databus), .rda(rda), .tbr(tbr), .txd(txd), .rxd(rxd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // One bus access; the access happens on the posedge inside the task.
  task automatic applyStimulus(input logic rw, input logic [1:0] addr,
                               input logic [7:0] wdata, output logic [7:0] rdata);
    @(negedge clk);
    iocs     = 1'b1;
    iorw     = rw;
    ioaddr   = addr;
    tb_data  = wdata;
    tb_drive = !rw;
    #1 rdata = databus;
    @(posedge clk);
    #1;
    iocs     = 1'b0;
    iorw     = 1'b1;
    tb_drive = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [7:0] wdata);
    logic [7:0] unused;
    applyStimulus(1'b0, addr, wdata, unused);
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [7:0] rdata);
    applyStimulus(1'b1, addr, 8'h00, rdata);
  endtask

  task automatic wait_rda(input int budget);
    int k = 0;
    while (!rda && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic wait_tbr(input int budget);
    int k = 0;
    while (!tbr && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic wait_tx_frames(input int n, input int budget);
    int k = 0;
    while (tx_data_q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
  endtask

  // Bit-bang one frame on rxd; a bad frame holds the stop bit low for 3/4 bit.
  task automatic send_rx_frame(input logic [7:0] d, input logic good_stop);
    @(negedge clk);
    tb_rxd = 1'b0;
    repeat (bit_cycles) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      tb_rxd = d[i];
      repeat (bit_cycles) @(negedge clk);
    end
    if (good_stop) begin
      tb_rxd = 1'b1;
      repeat (bit_cycles) @(negedge clk);
    end else begin
      tb_rxd = 1'b0;
      repeat (bit_cycles * 3 / 4) @(negedge clk);
      tb_rxd = 1'b1;
      repeat (bit_cycles / 4) @(negedge clk);
    end
  endtask

  // txd monitor: a low level starts a frame, then each bit is sampled at
  // its midpoint using the bit period the bench expects.
  initial begin
    int         start;
    logic [7:0] d;
    forever begin
      @(negedge clk);
      if (mon_en && txd === 1'b0) begin
        start = cyc;
        repeat (bit_cycles / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (bit_cycles) @(negedge clk);
          d[i] = txd;
        end
        repeat (bit_cycles) @(negedge clk);
        tx_data_q.push_back(d);
        tx_start_q.push_back(start);
        tx_stop_q.push_back(txd);
      end
    end
  end

  initial begin
    logic [7:0] rd;
    logic [7:0] d;
    logic [7:0] last_rx;
    int         wr_cyc;
    int         lat;

    rst = 1'b1; iocs = 1'b0; iorw = 1'b1; ioaddr = 2'b00;
    tb_data = 8'h00; tb_drive = 1'b0; tb_rxd = 1'b1;
    loopback = 1'b0; mon_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    $display("[TB] reset and idle");
    repeat (100) @(posedge clk);
    #1;
    checkOutput("reset_txd", 16'(txd), 16'h1);
    checkOutput("reset_tbr", 16'(tbr), 16'h1);
    checkOutput("reset_rda", 16'(rda), 16'h0);
    bus_read(2'b01, rd);
    checkOutput("reset_status", 16'(rd), 16'h02);
    bus_read(2'b00, rd);
    checkOutput("reset_rxbuf", 16'(rd), 16'h00);
    mon_en = 1'b1;

    $display("[TB] transmit A5 at divisor 3");
    bus_write(2'b10, 8'h03);
    bus_write(2'b11, 8'h00);
    bit_cycles = 64;
    bus_write(2'b00, 8'hA5);
    wr_cyc = cyc;
    checkOutput("tbr_after_write", 16'(tbr), 16'h0);
    @(posedge clk); #1;
    checkOutput("tbr_after_load", 16'(tbr), 16'h1);
    wait_tx_frames(1, 1500);
    checkOutput("tx_a5_count", 16'(tx_data_q.size()), 16'd1);
    if (tx_data_q.size() >= 1) begin
      checkOutput("tx_a5_data", 16'(tx_data_q[0]), 16'h00A5);
      checkOutput("tx_a5_stop", 16'(tx_stop_q[0]), 16'h1);
      lat = tx_start_q[0] - wr_cyc;
      checkOutput("tx_start_latency", 16'(lat >= 1 && lat <= 6), 16'h1);
    end
    repeat (100) @(posedge clk);

    $display("[TB] loopback frames");
    loopback = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = (i == 0) ? 8'h3C : 8'($urandom);
      bus_write(2'b00, d);
      wait_rda(1500);
      checkOutput("loop_rda_set", 16'(rda), 16'h1);
      bus_read(2'b00, rd);
      checkOutput("loop_rx_data", 16'(rd), 16'(d));
      checkOutput("loop_rda_clear", 16'(rda), 16'h0);
      if (i == 0) begin
        bus_read(2'b00, rd);
        checkOutput("loop_rx_stable", 16'(rd), 16'(d));
      end
      last_rx = d;
      repeat (60) @(posedge clk);
    end
    repeat (100) @(posedge clk);
    loopback = 1'b0;

    $display("[TB] short glitch on rxd");
    @(negedge clk);
    tb_rxd = 1'b0;
    repeat (16) @(negedge clk);
    tb_rxd = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    checkOutput("glitch_rda", 16'(rda), 16'h0);
    bus_read(2'b01, rd);
    checkOutput("glitch_status", 16'(rd), 16'h02);
    d = 8'($urandom);
    send_rx_frame(d, 1'b1);
    wait_rda(200);
    checkOutput("after_glitch_rda", 16'(rda), 16'h1);
    bus_read(2'b00, rd);
    checkOutput("after_glitch_data", 16'(rd), 16'(d));
    last_rx = d;

    $display("[TB] framing error");
    d = 8'($urandom);
    send_rx_frame(d, 1'b0);
    repeat (200) @(posedge clk);
    #1;
    checkOutput("ferr_rda", 16'(rda), 16'h0);
    bus_read(2'b01, rd);
    checkOutput("ferr_status1", 16'(rd), 16'h06);
    bus_read(2'b01, rd);
    checkOutput("ferr_status2", 16'(rd), 16'h02);
    bus_read(2'b00, rd);
    checkOutput("ferr_discard", 16'(rd), 16'(last_rx));

    $display("[TB] overrun");
    d = 8'($urandom);
    send_rx_frame(d, 1'b1);
    d = 8'($urandom);
    send_rx_frame(d, 1'b1);
    wait_rda(200);
    checkOutput("overrun_rda", 16'(rda), 16'h1);
    bus_read(2'b00, rd);
    checkOutput("overrun_data", 16'(rd), 16'(d));

    $display("[TB] back-to-back transmit");
    tx_data_q.delete(); tx_start_q.delete(); tx_stop_q.delete();
    bus_write(2'b00, 8'h11);
    wait_tbr(20);
    checkOutput("b2b_tbr_ready", 16'(tbr), 16'h1);
    bus_write(2'b00, 8'h22);
    checkOutput("b2b_tbr_full", 16'(tbr), 16'h0);
    bus_write(2'b00, 8'h33);
    checkOutput("b2b_tbr_still_full", 16'(tbr), 16'h0);
    wait_tx_frames(2, 2500);
    repeat (1500) @(posedge clk);
    checkOutput("b2b_count", 16'(tx_data_q.size()), 16'd2);
    if (tx_data_q.size() >= 2) begin
      checkOutput("b2b_first", 16'(tx_data_q[0]), 16'h0011);
      checkOutput("b2b_second", 16'(tx_data_q[1]), 16'h0022);
      checkOutput("b2b_gap", 16'(tx_start_q[1] - tx_start_q[0]), 16'(10 * bit_cycles));
      checkOutput("b2b_stop", 16'({tx_stop_q[0], tx_stop_q[1]}), 16'h3);
    end

    $display("[TB] divisor 0 loopback");
    tx_data_q.delete(); tx_start_q.delete(); tx_stop_q.delete();
    bit_cycles = 16;
    bus_write(2'b10, 8'h00);
    bus_write(2'b11, 8'h00);
    loopback = 1'b1;
    d = 8'($urandom);
    bus_write(2'b00, d);
    wait_rda(400);
    checkOutput("div0_rda", 16'(rda), 16'h1);
    bus_read(2'b00, rd);
    checkOutput("div0_rx_data", 16'(rd), 16'(d));
    repeat (50) @(posedge clk);
    checkOutput("div0_tx_count", 16'(tx_data_q.size()), 16'd1);
    if (tx_data_q.size() >= 1)
      checkOutput("div0_tx_data", 16'(tx_data_q[0]), 16'(d));

    $display("[TB] reset mid-frame");
    loopback = 1'b0;
    mon_en = 1'b0;
    bit_cycles = 64;
    bus_write(2'b10, 8'h03);
    bus_write(2'b11, 8'h00);
    bus_write(2'b00, 8'h00);
    repeat (150) @(posedge clk);
    #1;
    checkOutput("midframe_txd_low", 16'(txd), 16'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("midframe_reset_txd", 16'(txd), 16'h1);
    checkOutput("midframe_reset_tbr", 16'(tbr), 16'h1);
    @(negedge clk);
    rst = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    checkOutput("post_reset_txd", 16'(txd), 16'h1);
    bus_read(2'b01, rd);
    checkOutput("post_reset_status", 16'(rd), 16'h02);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spart_core.md
Name: spart_core

Overview:
- Serial port (SPART) that the processor-side bus driver talks to through the iocs/iorw/ioaddr/databus register interface.
- Contains a programmable baud-rate generator, a transmit buffer and serializer, and a receiver with 16x oversampling and a receive buffer.
- Drives txd and samples rxd at the board pins. Reports buffer state to the driver through tbr and rda.

Parameters:
- DIV_RESET, 16'h0516: divisor value after reset (2400 baud at 50 MHz with 16x oversampling).
- SYNC_STAGES, 2: number of flip-flop stages synchronizing rxd.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- iocs  input  1  chip select; a bus access happens on each clk edge where iocs=1.
- iorw  input  1  1 = read (SPART drives databus), 0 = write.
- ioaddr  input  2  00 = TX buffer (write) / RX buffer (read); 01 = status (read); 10 = divisor low byte (write); 11 = divisor high byte (write).
- databus  inout  8  bidirectional data bus.
- rda  output  1  receive data available.
- tbr  output  1  transmit buffer ready (empty).
- txd  output  1  serial transmit line, idle high.
- rxd  input  1  serial receive line, asynchronous.

Behaviour:
- Reset values:
  - txd=1, tbr=1, rda=0.
  - RX buffer=0; framing-error flag ferr=0.
  - divisor=DIV_RESET; baud counter=DIV_RESET.
  - TX and RX state machines in IDLE.
  - databus released (Z).
  - A reset mid-frame aborts the frame; txd returns to 1 on the next cycle.
- databus drive:
  - Combinational, only when iocs=1 and iorw=1 and ioaddr[1]=0; Z otherwise.
  - ioaddr=00 drives the RX buffer.
  - ioaddr=01 drives {5'b0, ferr, tbr, rda}.
- Register writes (iocs=1, iorw=0), taking effect at the edge:
  - ioaddr=10 writes divisor[7:0].
  - ioaddr=11 writes divisor[15:8] and reloads the baud counter with the new 16-bit divisor.
  - ioaddr=00 loads the TX buffer and clears tbr. If tbr=0, the write is ignored and the buffer is unchanged.
- Reads:
  - RX buffer read clears rda at that edge; the data stays stable in the buffer.
  - Status read clears ferr at that edge.
  - Reads at ioaddr 10/11 drive nothing and have no effect.
- Baud generator:
  - 16-bit down counter. When it reaches 0 it emits a 1-cycle tick and reloads the divisor.
  - Tick period = divisor+1 cycles; divisor 0 gives a tick every cycle.
  - Bit time = 16 ticks.
- TX state machine (IDLE, START, DATA, STOP):
  - IDLE, tbr=0: move the buffer into the shift register, set tbr=1, go to START. txd goes 0 at the next tick boundary.
  - START: 16 ticks at txd=0.
  - DATA: 8 bits LSB first, 16 ticks each.
  - STOP: 16 ticks at txd=1, then IDLE.
  - A new byte written during a frame is sent back-to-back, immediately after STOP.
- RX state machine (IDLE, START, DATA, STOP):
  - rxd passes through SYNC_STAGES flops first.
  - IDLE: a synchronized 0 seen on a tick goes to START.
  - START: after 8 ticks (mid-bit), rxd=1 is a false start and returns to IDLE; otherwise go to DATA.
  - DATA: sample every 16 ticks, 8 bits, LSB first.
  - STOP: sample after 16 ticks.
    - rxd=1: load the RX buffer, set rda=1.
    - rxd=0: set ferr=1, discard the byte, leave rda unchanged.
    - Either way, return to IDLE.
  - Overrun: a new valid frame while rda=1 overwrites the buffer; rda stays 1.
- Simultaneous events:
  - RX frame completion on the same edge as an RX buffer read: the new byte is loaded and rda stays 1 (set wins over clear).
  - TX buffer write on the same edge the shifter takes the buffer: not possible, because the write requires tbr=1, i.e. an empty buffer.

Test Plan:
- Reset, then idle 100 cycles -> txd=1, tbr=1, rda=0; databus Z; status read returns 8'h02.
- Write 8'h03 to ioaddr 10, 8'h00 to ioaddr 11 -> tick every 4 cycles, bit = 64 cycles; write 8'hA5 to ioaddr 00 -> tbr=0 for one cycle then 1. txd shows 0, then bits 1,0,1,0,0,1,0,1 (LSB first), then 1, each bit 64 cycles.
- Loopback txd->rxd, divisor 3, send 8'h3C -> rda=1 about 10 bit times later. Read ioaddr 00 returns 8'h3C; rda=0 the cycle after the read.
- Drive rxd low for 16 cycles only (glitch shorter than half a bit at divisor 3) -> rda stays 0, ferr stays 0, receiver returns to IDLE.
- Send a frame with the stop bit forced to 0 -> rda=0; status read returns ferr=1 (8'h06); a second status read returns ferr=0.
- Write 8'h11, then 8'h22 while tbr=1, then a third byte while tbr=0 -> only 8'h11 and 8'h22 are sent, back-to-back; third byte ignored. Reset asserted mid-frame -> txd=1 next cycle.
